// File: rtl/keypad_pkg.sv
// Shared sizes, key index/bitmap types and the priority helper for the keypad scanner.
package keypad_pkg;

  localparam int unsigned NUM_ROWS  = 4;
  localparam int unsigned NUM_COLS  = 4;
  localparam int unsigned KEY_COUNT = 16;

  typedef logic [3:0]           key_idx_t;
  typedef logic [KEY_COUNT-1:0] key_map_t;

  // Index of the lowest set bit; 0 when the map is empty.
  function automatic key_idx_t lowest_set(input key_map_t map);
    key_idx_t idx;
    idx = '0;
    for (int i = KEY_COUNT - 1; i >= 0; i--) begin
      if (map[i]) idx = key_idx_t'(i);
    end
    return idx;
  endfunction

endpackage

// File: rtl/keypad_frame_debounce.sv
// Frame-level debounce: confirms a raw key frame after DEBOUNCE_FRAMES identical frames and
// reports the lowest newly pressed key as a one-cycle event.
module keypad_frame_debounce
  import keypad_pkg::*;
#(
  parameter int unsigned DEBOUNCE_FRAMES = 3
) (
  input  logic     clk,
  input  logic     rst,
  input  key_map_t raw_i,
  input  logic     frame_end_i,
  output key_map_t keys_o,
  output logic     key_valid_o,
  output key_idx_t key_code_o
);

  localparam int unsigned MatchW = $clog2(DEBOUNCE_FRAMES + 1);
  localparam logic [MatchW-1:0] MatchMax = MatchW'(DEBOUNCE_FRAMES);

  logic [MatchW-1:0] match_q, match_d;
  key_map_t          prev_q, prev_d;
  key_map_t          keys_q, keys_d;
  logic              pend_q, pend_d;
  key_idx_t          pend_code_q, pend_code_d;
  logic              valid_q, valid_d;
  key_idx_t          code_q, code_d;
  key_map_t          new_keys;

  // Next-state: run-length match count, confirmed bitmap, and a one-cycle-delayed press event.
  always_comb begin
    match_d     = match_q;
    prev_d      = prev_q;
    keys_d      = keys_q;
    pend_d      = 1'b0;
    pend_code_d = pend_code_q;
    new_keys    = '0;
    if (frame_end_i) begin
      if (raw_i == prev_q) begin
        if (match_q != MatchMax) match_d = match_q + MatchW'(1);
      end else begin
        match_d = MatchW'(1);
      end
      prev_d = raw_i;
      if (match_d >= MatchMax) keys_d = raw_i;
      new_keys    = keys_d & ~keys_q;
      pend_d      = |new_keys;
      pend_code_d = lowest_set(new_keys);
    end
    // The event is presented the cycle after the bitmap changes.
    valid_d = pend_q;
    code_d  = pend_q ? pend_code_q : code_q;
  end

  // State registers with asynchronous clear.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      match_q     <= '0;
      prev_q      <= '0;
      keys_q      <= '0;
      pend_q      <= 1'b0;
      pend_code_q <= '0;
      valid_q     <= 1'b0;
      code_q      <= '0;
    end else begin
      match_q     <= match_d;
      prev_q      <= prev_d;
      keys_q      <= keys_d;
      pend_q      <= pend_d;
      pend_code_q <= pend_code_d;
      valid_q     <= valid_d;
      code_q      <= code_d;
    end
  end

  assign keys_o      = keys_q;
  assign key_valid_o = valid_q;
  assign key_code_o  = code_q;

endmodule

// File: rtl/keypad_scanner.sv
// 4x4 key matrix scanner: walks a low column across the matrix, samples synchronized rows into
// a raw frame, and hands each completed frame to the debouncer.
module keypad_scanner
  import keypad_pkg::*;
#(
  parameter int unsigned COL_CYCLES      = 100000,
  parameter int unsigned DEBOUNCE_FRAMES = 3
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [NUM_ROWS-1:0] row_n,
  output logic [NUM_COLS-1:0] col_n,
  output key_map_t            keys,
  output logic                key_down,
  output logic                key_valid,
  output key_idx_t            key_code
);

  localparam int unsigned CntW = $clog2(COL_CYCLES);
  localparam logic [CntW-1:0] CntLast = CntW'(COL_CYCLES - 1);

  logic [NUM_ROWS-1:0] row_meta_q, row_sync_q;
  logic [CntW-1:0]     cnt_q, cnt_d;
  logic [1:0]          col_q, col_d;
  key_map_t            raw_q, raw_d;
  logic                capture;
  logic                frame_end;

  // Two-flop synchronizer for the asynchronous row inputs; clears to the idle (pulled-up) level.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      row_meta_q <= '1;
      row_sync_q <= '1;
    end else begin
      row_meta_q <= row_n;
      row_sync_q <= row_meta_q;
    end
  end

  // Column timing and raw capture; raw_d already holds the current column's bits on capture.
  always_comb begin
    capture = (cnt_q == CntLast);
    cnt_d   = capture ? '0 : cnt_q + CntW'(1);
    col_d   = capture ? col_q + 2'd1 : col_q;
    raw_d   = raw_q;
    if (capture) raw_d[{col_q, 2'b00} +: NUM_ROWS] = ~row_sync_q;
    frame_end = capture && (col_q == 2'd3);
  end

  // Scan state registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q <= '0;
      col_q <= '0;
      raw_q <= '0;
    end else begin
      cnt_q <= cnt_d;
      col_q <= col_d;
      raw_q <= raw_d;
    end
  end

  assign col_n = ~(NUM_COLS'(1) << col_q);

  keypad_frame_debounce #(
    .DEBOUNCE_FRAMES(DEBOUNCE_FRAMES)
  ) u_debounce (
    .clk        (clk),
    .rst        (rst),
    .raw_i      (raw_d),
    .frame_end_i(frame_end),
    .keys_o     (keys),
    .key_valid_o(key_valid),
    .key_code_o (key_code)
  );

  assign key_down = |keys;

endmodule

// File: tb/tb_keypad_scanner.sv
// Self-checking bench for keypad_scanner: a frame-level model of the matrix, debounce and event
// rules is compared against the DUT every cycle, plus directed literal expectations.
module tb_keypad_scanner;

  localparam int COLC  = 8;
  localparam int DEB   = 2;
  localparam int FRAME = 4 * COLC;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic [3:0]  row_n;
  logic [3:0]  col_n;
  logic [15:0] keys;
  logic        key_down;
  logic        key_valid;
  logic [3:0]  key_code;
  logic [15:0] pressed = '0;

  keypad_scanner #(
    .COL_CYCLES     (COLC),
    .DEBOUNCE_FRAMES(DEB)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .row_n    (row_n),
    .col_n    (col_n),
    .keys     (keys),
    .key_down (key_down),
    .key_valid(key_valid),
    .key_code (key_code)
  );

  always #5 clk = ~clk;

  // Passive matrix: a pressed key pulls its row low while its column is driven low.
  always_comb begin
    row_n = 4'hF;
    for (int c = 0; c < 4; c++)
      for (int r = 0; r < 4; r++)
        if (pressed[c*4+r] && !col_n[c]) row_n[r] = 1'b0;
  end

  int errors = 0;
  int checks = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [3:0] lowest(input logic [15:0] m);
    for (int i = 0; i < 16; i++) if (m[i]) return 4'(i);
    return 4'd0;
  endfunction

  // Model: t is the cycle index since reset release; the raw frame sees the pressed set as it was
  // two cycles before each column's last cycle, and keys follow the last DEB identical frames.
  int          t = 0;
  int          mcol;
  int          evt_cyc = -1;
  bit          stable;
  logic [15:0] frame = '0;
  logic [15:0] m_keys = '0;
  logic [3:0]  evt_code = '0;
  logic [3:0]  m_code = '0;
  logic [15:0] hist[$];

  always @(posedge clk) begin
    if (rst) begin
      t = 0; frame = '0; m_keys = '0; evt_cyc = -1; evt_code = '0; m_code = '0;
      hist.delete();
    end else begin
      mcol = (t / COLC) % 4;
      if (t % COLC == COLC - 3)
        for (int r = 0; r < 4; r++) frame[mcol*4+r] = pressed[mcol*4+r];
      if (t % FRAME == FRAME - 1) begin
        hist.push_back(frame);
        stable = (hist.size() >= DEB);
        if (stable)
          for (int i = 1; i < DEB; i++)
            if (hist[hist.size()-1-i] != frame) stable = 1'b0;
        if (stable) begin
          if ((frame & ~m_keys) != 16'h0) begin
            evt_cyc  = t + 2;
            evt_code = lowest(frame & ~m_keys);
          end
          m_keys = frame;
        end
      end
      t++;
      if (t == evt_cyc) m_code = evt_code;
    end
  end

  int         pulses = 0;
  logic [3:0] exp_col;

  // Cycle-by-cycle comparison against the model, away from the active edge.
  always @(negedge clk) begin
    if (!rst) begin
      exp_col = ~(4'b0001 << ((t / COLC) % 4));
      check("col_n", col_n, exp_col);
      check("keys", keys, m_keys);
      check("key_down", key_down, |m_keys);
      check("key_valid", key_valid, t == evt_cyc);
      check("key_code", key_code, m_code);
      if (key_valid) pulses++;
    end
  end

  task automatic step(input int n);
    repeat (n) @(negedge clk);
    #1;
  endtask

  int p0;
  int w;

  initial begin
    // Reset values
    #1 rst = 1'b1;
    #1;
    check("rst_col_n", col_n, 4'b1110);
    check("rst_keys", keys, 16'h0);
    check("rst_key_down", key_down, 1'b0);
    check("rst_key_valid", key_valid, 1'b0);
    check("rst_key_code", key_code, 4'h0);
    repeat (2) @(posedge clk);
    @(negedge clk) rst = 1'b0;

    // 1: idle scan
    step(9);
    check("t1_col1", col_n, 4'b1101);
    step(4 * FRAME - 9);
    check("t1_keys", keys, 16'h0);
    check("t1_pulses", pulses, 0);

    // 2: single key press and release
    p0 = pulses;
    pressed = 16'h0040;
    step(4 * FRAME);
    check("t2_keys", keys, 16'h0040);
    check("t2_key_down", key_down, 1'b1);
    check("t2_code", key_code, 4'd6);
    check("t2_pulses", pulses - p0, 1);
    pressed = '0;
    step(3 * FRAME);
    check("t2_rel_keys", keys, 16'h0);
    check("t2_rel_code", key_code, 4'd6);
    check("t2_rel_pulses", pulses - p0, 1);

    // 3: bouncing key never confirms
    p0 = pulses;
    for (int i = 0; i < 6; i++) begin
      pressed = pressed ^ 16'h0040;
      step(FRAME);
    end
    check("t3_keys", keys, 16'h0);
    check("t3_pulses", pulses - p0, 0);

    // 4: two keys in one frame give one event
    p0 = pulses;
    pressed = 16'h0420;
    step(4 * FRAME);
    check("t4_keys", keys, 16'h0420);
    check("t4_code", key_code, 4'd5);
    check("t4_pulses", pulses - p0, 1);
    pressed = '0;
    step(3 * FRAME);
    check("t4_rel_keys", keys, 16'h0);

    // 5: second key added while first held
    p0 = pulses;
    pressed = 16'h0040;
    step(4 * FRAME);
    check("t5_code6", key_code, 4'd6);
    pressed = 16'h0240;
    step(4 * FRAME);
    check("t5_keys", keys, 16'h0240);
    check("t5_code9", key_code, 4'd9);
    check("t5_pulses", pulses - p0, 2);
    pressed = 16'h0040;
    step(3 * FRAME);
    check("t5_rel_keys", keys, 16'h0040);
    check("t5_rel_pulses", pulses - p0, 2);

    // 6: asynchronous reset mid-column with key held, then re-report
    @(posedge clk);
    #3 rst = 1'b1;
    #1;
    check("t6_col_n", col_n, 4'b1110);
    check("t6_keys", keys, 16'h0);
    check("t6_key_down", key_down, 1'b0);
    check("t6_key_valid", key_valid, 1'b0);
    check("t6_key_code", key_code, 4'h0);
    step(2);
    @(negedge clk) rst = 1'b0;
    w = 0;
    while (!key_valid && w < 3 * FRAME + 2) begin
      step(1);
      w++;
    end
    check("t6_rereport_seen", key_valid, 1'b1);
    check("t6_rereport_code", key_code, 4'd6);
    step(2 * FRAME);
    check("t6_keys", keys, 16'h0040);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
